// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles every signal between the data-memory arbiter and its environment:
//   the two request ports (0 = core load/store unit, 1 = DMA/debug), the
//   shared response data, and the single-ported data memory bus.
//
//   Signal summary (directions as seen by the arbiter, i.e. the slave side):
//     r0_valid/r1_valid   in   request valid
//     r0_ready/r1_ready   out  request accepted when valid && ready at the edge
//     r0_we/r1_we         in   1 = store, 0 = load
//     r0_addr/r1_addr     in   word address, DM_ADDRESS bits
//     r0_wdata/r1_wdata   in   store data, DATA_W bits
//     r0_rsp_valid/r1_... out  one-cycle completion pulse
//     rsp_rdata           out  load data, meaningful while an rsp_valid is high
//     MemRead/MemWrite    out  memory strobes
//     a / wd              out  memory address / write data
//     rd                  in   memory read data, valid while MemRead is high
//
//   Modports:
//     slave  - the arbiter
//     master - requesters plus memory model (testbench / surrounding system)
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 64
);
    // Port 0 request / response
    logic                  r0_valid;
    logic                  r0_ready;
    logic                  r0_we;
    logic [DM_ADDRESS-1:0] r0_addr;
    logic [DATA_W-1:0]     r0_wdata;
    logic                  r0_rsp_valid;

    // Port 1 request / response
    logic                  r1_valid;
    logic                  r1_ready;
    logic                  r1_we;
    logic [DM_ADDRESS-1:0] r1_addr;
    logic [DATA_W-1:0]     r1_wdata;
    logic                  r1_rsp_valid;

    // Shared load data
    logic [DATA_W-1:0]     rsp_rdata;

    // Data memory bus
    logic                  MemRead;
    logic                  MemWrite;
    logic [DM_ADDRESS-1:0] a;
    logic [DATA_W-1:0]     wd;
    logic [DATA_W-1:0]     rd;

    modport slave (
        input  r0_valid, r0_we, r0_addr, r0_wdata,
        input  r1_valid, r1_we, r1_addr, r1_wdata,
        input  rd,
        output r0_ready, r0_rsp_valid,
        output r1_ready, r1_rsp_valid,
        output rsp_rdata,
        output MemRead, MemWrite, a, wd
    );

    modport master (
        output r0_valid, r0_we, r0_addr, r0_wdata,
        output r1_valid, r1_we, r1_addr, r1_wdata,
        output rd,
        input  r0_ready, r0_rsp_valid,
        input  r1_ready, r1_rsp_valid,
        input  rsp_rdata,
        input  MemRead, MemWrite, a, wd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Two-port round-robin arbiter in front of a single-ported data memory.
//   Each access takes a fixed three cycles:
//     IDLE : ready offered to one requester; acceptance latches the request
//     ACC  : exactly one memory strobe with the latched address / data;
//            load data is captured into rsp_rdata at the end of this cycle
//     RSP  : one-cycle rsp_valid pulse to the owner of the access
//
//   Ports:
//     clk    in  single clock, rising edge
//     reset  in  asynchronous, active-high; aborts any in-flight access
//     bus    dmem_arbiter_if.slave - request ports, response, memory bus
//
//   Parameters:
//     DM_ADDRESS  word-address width (must match the interface instance)
//     DATA_W      data word width    (must match the interface instance)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 64
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t state;

    // Port that was granted most recently (1 after reset so port 0 wins the
    // first tie) and the owner of the access currently in flight.
    logic last_grant;
    logic owner;

    // Arbitration result for this cycle; nonzero only in IDLE.
    logic grant0;
    logic grant1;

    // Payload of the winning port, selected before it is latched.
    logic                  sel_we;
    logic [DM_ADDRESS-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_wdata;

    // -----------------------------------------------------------------------
    // Arbitration. Ready must follow valid within the same cycle so that a
    // request presented in the first cycle after reset can be accepted
    // immediately; hence ready is combinational. It is gated with reset so
    // that all readys are low while reset is held.
    // -----------------------------------------------------------------------
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !reset) begin
            if (bus.r0_valid && bus.r1_valid) begin
                // Tie: the port that did not win last time goes now.
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = bus.r0_valid;
                grant1 = bus.r1_valid;
            end
        end
    end

    always_comb begin
        bus.r0_ready = grant0;
        bus.r1_ready = grant1;
    end

    always_comb begin
        if (grant1) begin
            sel_we    = bus.r1_we;
            sel_addr  = bus.r1_addr;
            sel_wdata = bus.r1_wdata;
        end else begin
            sel_we    = bus.r0_we;
            sel_addr  = bus.r0_addr;
            sel_wdata = bus.r0_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Access sequencer. The a/wd/MemRead/MemWrite registers double as the
    // latched request: they are loaded on acceptance, so they present the
    // request during ACC and are cleared again on leaving ACC. MemRead being
    // high in ACC is therefore the latched "this is a load" flag.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            last_grant       <= 1'b1;
            owner            <= 1'b0;
            bus.MemRead      <= 1'b0;
            bus.MemWrite     <= 1'b0;
            bus.a            <= '0;
            bus.wd           <= '0;
            bus.rsp_rdata    <= '0;
            bus.r0_rsp_valid <= 1'b0;
            bus.r1_rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        owner        <= grant1;
                        last_grant   <= grant1;
                        bus.a        <= sel_addr;
                        bus.wd       <= sel_wdata;
                        bus.MemRead  <= !sel_we;
                        bus.MemWrite <= sel_we;
                        state        <= ACC;
                    end
                end

                ACC: begin
                    if (bus.MemRead) begin
                        bus.rsp_rdata <= bus.rd;
                    end
                    bus.MemRead      <= 1'b0;
                    bus.MemWrite     <= 1'b0;
                    bus.a            <= '0;
                    bus.wd           <= '0;
                    bus.r0_rsp_valid <= !owner;
                    bus.r1_rsp_valid <= owner;
                    state            <= RSP;
                end

                RSP: begin
                    bus.r0_rsp_valid <= 1'b0;
                    bus.r1_rsp_valid <= 1'b0;
                    state            <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Structural invariants of the bus.
    // -----------------------------------------------------------------------
    a_strobe_onehot: assert property (@(posedge clk) disable iff (reset)
        !(bus.MemRead && bus.MemWrite));

    a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
        !(bus.r0_ready && bus.r1_ready));

    a_rsp_onehot: assert property (@(posedge clk) disable iff (reset)
        !(bus.r0_rsp_valid && bus.r1_rsp_valid));

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. A timestamp-based reference model
//   predicts every output on every cycle; directed scenarios additionally
//   check hand-computed literals from an event log.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW = 9;
    localparam int DW = 64;

    logic clk;
    logic reset;

    dmem_arbiter_if #(.DM_ADDRESS(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Contents of never-written memory words.
    function automatic logic [63:0] init_word(input logic [AW-1:0] addr);
        return {32'hA5A5_0000, 23'd0, addr};
    endfunction

    // ---------------- memory environment ----------------
    logic [63:0] env_mem [512];
    bit          env_wr  [512];

    assign bus.rd = bus.MemRead ? (env_wr[bus.a] ? env_mem[bus.a] : init_word(bus.a))
                                : 64'hBAD0_BAD0_BAD0_BAD0;

    always @(posedge clk) begin
        if (bus.MemWrite) begin
            env_mem[bus.a] <= bus.wd;
            env_wr[bus.a]  <= 1'b1;
        end
    end

    // ---------------- requesters ----------------
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [63:0]   wdata;
    } req_t;

    req_t q0[$];
    req_t q1[$];
    bit   took0, took1;
    req_t dropped;

    function automatic req_t mk(input bit we, input logic [AW-1:0] addr, input logic [63:0] d);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = d;
        return r;
    endfunction

    initial begin
        bus.r0_valid = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
        bus.r1_valid = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (took0 && q0.size() > 0) dropped = q0.pop_front();
            if (took1 && q1.size() > 0) dropped = q1.pop_front();
            if (q0.size() > 0) begin
                bus.r0_valid = 1'b1; bus.r0_we = q0[0].we;
                bus.r0_addr = q0[0].addr; bus.r0_wdata = q0[0].wdata;
            end else begin
                bus.r0_valid = 1'b0;
            end
            if (q1.size() > 0) begin
                bus.r1_valid = 1'b1; bus.r1_we = q1[0].we;
                bus.r1_addr = q1[0].addr; bus.r1_wdata = q1[0].wdata;
            end else begin
                bus.r1_valid = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    // An accepted request at the edge ending cycle m_acc strobes memory in
    // cycle m_acc+1, responds in m_acc+2 and frees the arbiter from m_acc+3.
    int          cyc;
    bit          m_has;
    int          m_acc;
    bit          m_last;
    bit          m_owner;
    bit          m_we;
    logic [AW-1:0] m_addr;
    logic [63:0] m_wdata;
    logic [63:0] m_rdata;
    logic [63:0] m_mem [512];
    bit          m_wr  [512];

    function automatic bit m_idle();
        return !m_has || (cyc >= m_acc + 3);
    endfunction
    function automatic bit m_win0();
        return bus.r0_valid && (!bus.r1_valid || m_last);
    endfunction
    function automatic bit m_win1();
        return bus.r1_valid && (!bus.r0_valid || !m_last);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc     <= 0;
            m_has   <= 1'b0;
            m_last  <= 1'b1;
            m_rdata <= '0;
        end else begin
            cyc <= cyc + 1;
            if (m_idle() && (bus.r0_valid || bus.r1_valid)) begin
                m_has   <= 1'b1;
                m_acc   <= cyc;
                m_owner <= m_win1();
                m_last  <= m_win1();
                m_we    <= m_win1() ? bus.r1_we    : bus.r0_we;
                m_addr  <= m_win1() ? bus.r1_addr  : bus.r0_addr;
                m_wdata <= m_win1() ? bus.r1_wdata : bus.r0_wdata;
            end
            if (m_has && cyc == m_acc + 1) begin
                if (m_we) begin
                    m_mem[m_addr] <= m_wdata;
                    m_wr[m_addr]  <= 1'b1;
                end else begin
                    m_rdata <= m_wr[m_addr] ? m_mem[m_addr] : init_word(m_addr);
                end
            end
        end
    end

    // ---------------- per-cycle compare + event log ----------------
    int          acc_port[$], acc_cyc[$];
    int          rsp_port[$], rsp_cyc[$];
    logic [63:0] rsp_data[$];
    int          stb_cyc[$], stb_we[$], stb_a[$];

    bit e_stb, e_rsp, e0, e1;

    always @(negedge clk) begin
        e_stb = !reset && m_has && (cyc == m_acc + 1);
        e_rsp = !reset && m_has && (cyc == m_acc + 2);
        e0    = !reset && m_idle() && m_win0();
        e1    = !reset && m_idle() && m_win1();
        chk("r0_ready",     64'(bus.r0_ready),     64'(e0));
        chk("r1_ready",     64'(bus.r1_ready),     64'(e1));
        chk("MemRead",      64'(bus.MemRead),      64'(e_stb && !m_we));
        chk("MemWrite",     64'(bus.MemWrite),     64'(e_stb && m_we));
        chk("a",            64'(bus.a),            e_stb ? 64'(m_addr) : 64'd0);
        chk("wd",           bus.wd,                e_stb ? m_wdata : 64'd0);
        chk("r0_rsp_valid", 64'(bus.r0_rsp_valid), 64'(e_rsp && !m_owner));
        chk("r1_rsp_valid", 64'(bus.r1_rsp_valid), 64'(e_rsp && m_owner));
        chk("rsp_rdata",    bus.rsp_rdata,         m_rdata);

        took0 = bus.r0_valid && bus.r0_ready;
        took1 = bus.r1_valid && bus.r1_ready;
        if (took0) begin acc_port.push_back(0); acc_cyc.push_back(cyc); end
        if (took1) begin acc_port.push_back(1); acc_cyc.push_back(cyc); end
        if (bus.MemRead || bus.MemWrite) begin
            stb_cyc.push_back(cyc); stb_we.push_back(int'(bus.MemWrite)); stb_a.push_back(int'(bus.a));
        end
        if (bus.r0_rsp_valid) begin rsp_port.push_back(0); rsp_cyc.push_back(cyc); rsp_data.push_back(bus.rsp_rdata); end
        if (bus.r1_rsp_valid) begin rsp_port.push_back(1); rsp_cyc.push_back(cyc); rsp_data.push_back(bus.rsp_rdata); end
    end

    task automatic clear_logs();
        acc_port.delete(); acc_cyc.delete();
        rsp_port.delete(); rsp_cyc.delete(); rsp_data.delete();
        stb_cyc.delete(); stb_we.delete(); stb_a.delete();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain_in_time", 64'(n < 300), 64'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        took0 = 1'b0;
        took1 = 1'b0;
        reset = 1'b1;
        #2;
        chk("reset_a",         64'(bus.a),         64'd0);
        chk("reset_MemRead",   64'(bus.MemRead),   64'd0);
        chk("reset_rsp_rdata", bus.rsp_rdata,      64'd0);

        // Both ports valid from reset: alternate 0,1,0,1,... every 3 cycles.
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(1'b0, AW'(10 + i), 64'd0));
            q1.push_back(mk(1'b0, AW'(20 + i), 64'd0));
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wait_done();
        chk("rr_count", 64'(acc_port.size()), 64'd6);
        for (int i = 0; i < acc_port.size() && i < 6; i++) begin
            chk("rr_port", 64'(acc_port[i]), 64'(i % 2));
            chk("rr_cycle", 64'(acc_cyc[i]), 64'(3 * i));
        end
        if (rsp_data.size() >= 2)
            chk("rr_load1_data", rsp_data[1], 64'hA5A5_0000_0000_0014);
        else
            chk("rr_rsp_count", 64'(rsp_data.size()), 64'd6);

        // Port 0 store then load at 0x005.
        clear_logs();
        q0.push_back(mk(1'b1, 9'h005, 64'hDEAD_BEEF_0000_0001));
        q0.push_back(mk(1'b0, 9'h005, 64'd0));
        wait_done();
        chk("st_ld_acc_count", 64'(acc_port.size()), 64'd2);
        chk("st_ld_rsp_count", 64'(rsp_port.size()), 64'd2);
        if (acc_port.size() == 2 && rsp_port.size() == 2 && stb_cyc.size() == 2) begin
            chk("st_strobe_we",    64'(stb_we[0]),  64'd1);
            chk("st_strobe_a",     64'(stb_a[0]),   64'h005);
            chk("st_strobe_cycle", 64'(stb_cyc[0]), 64'(acc_cyc[0] + 1));
            chk("st_rsp_cycle",    64'(rsp_cyc[0]), 64'(acc_cyc[0] + 2));
            chk("st_rsp_port",     64'(rsp_port[0]), 64'd0);
            chk("ld_next_accept",  64'(acc_cyc[1]), 64'(acc_cyc[0] + 3));
            chk("ld_strobe_we",    64'(stb_we[1]),  64'd0);
            chk("ld_data",         rsp_data[1],     64'hDEAD_BEEF_0000_0001);
        end

        // Top address store/load.
        clear_logs();
        q0.push_back(mk(1'b1, 9'h1FF, 64'h0123));
        q0.push_back(mk(1'b0, 9'h1FF, 64'd0));
        wait_done();
        chk("top_strobe_count", 64'(stb_a.size()), 64'd2);
        if (stb_a.size() == 2 && rsp_data.size() == 2) begin
            chk("top_st_a", 64'(stb_a[0]), 64'h1FF);
            chk("top_ld_a", 64'(stb_a[1]), 64'h1FF);
            chk("top_ld_data", rsp_data[1], 64'h0123);
        end

        // Port 1 store keeps the previous load data; then a port 0 load.
        clear_logs();
        q1.push_back(mk(1'b1, 9'h007, 64'h7777_7777_7777_7777));
        wait_done();
        chk("p1st_rsp_count", 64'(rsp_port.size()), 64'd1);
        if (rsp_port.size() == 1) begin
            chk("p1st_rsp_port", 64'(rsp_port[0]), 64'd1);
            chk("p1st_rdata_during", rsp_data[0], 64'h0123);
        end
        chk("p1st_rdata_after", bus.rsp_rdata, 64'h0123);
        clear_logs();
        q0.push_back(mk(1'b0, 9'h003, 64'd0));
        wait_done();
        if (rsp_data.size() == 1)
            chk("p0ld_data", rsp_data[0], 64'hA5A5_0000_0000_0003);
        else
            chk("p0ld_rsp_count", 64'(rsp_data.size()), 64'd1);

        // Only port 1 valid: three back-to-back grants on the 3-cycle cadence.
        clear_logs();
        for (int i = 0; i < 3; i++) q1.push_back(mk(1'b1, AW'(48 + i), 64'(i + 1)));
        wait_done();
        chk("p1only_count", 64'(acc_port.size()), 64'd3);
        for (int i = 0; i < acc_port.size() && i < 3; i++) begin
            chk("p1only_port", 64'(acc_port[i]), 64'd1);
            if (i > 0) chk("p1only_gap", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd3);
        end

        // Reset in the middle of a port 0 load.
        clear_logs();
        q0.push_back(mk(1'b0, 9'h040, 64'd0));
        n = 0;
        while (!bus.MemRead && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_saw_memread", 64'(bus.MemRead), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort_memread_async", 64'(bus.MemRead), 64'd0);
        chk("abort_a_async",       64'(bus.a),       64'd0);
        q0.push_back(mk(1'b0, 9'h041, 64'd0));
        q1.push_back(mk(1'b0, 9'h042, 64'd0));
        clear_logs();
        @(posedge clk);
        #1 reset = 1'b0;
        wait_done();
        chk("rearb_acc_count", 64'(acc_port.size()), 64'd2);
        chk("rearb_rsp_count", 64'(rsp_port.size()), 64'd2);
        if (acc_port.size() == 2 && rsp_port.size() == 2) begin
            chk("rearb_first_port",  64'(acc_port[0]), 64'd0);
            chk("rearb_first_cycle", 64'(acc_cyc[0]),  64'd0);
            chk("rearb_second_port", 64'(acc_port[1]), 64'd1);
            chk("rearb_rsp0_port",   64'(rsp_port[0]), 64'd0);
            chk("rearb_rsp0_data",   rsp_data[0],      64'hA5A5_0000_0000_0041);
            chk("rearb_rsp1_data",   rsp_data[1],      64'hA5A5_0000_0000_0042);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, data memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 64, data word width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports r0_valid / r1_valid  input  1 each  request valid from port 0 (core load/store unit) / port 1 (DMA/debug).
REQ-006 SHALL have ports r0_ready / r1_ready  output  1 each  request accepted this cycle when valid and ready are both high.
REQ-007 SHALL have ports r0_we / r1_we  input  1 each  1 = store, 0 = load.
REQ-008 SHALL have ports r0_addr / r1_addr  input  DM_ADDRESS each  word address.
REQ-009 SHALL have ports r0_wdata / r1_wdata  input  DATA_W each  store data.
REQ-010 SHALL have ports r0_rsp_valid / r1_rsp_valid  output  1 each  one-cycle completion pulse for loads and stores.
REQ-011 SHALL have port rsp_rdata  output  DATA_W  load data, meaningful only while an rsp_valid is high after a load.
REQ-012 SHALL have ports MemRead / MemWrite  output  1 each  memory strobes.
REQ-013 SHALL have ports a / wd  output  DM_ADDRESS / DATA_W  memory address and write data.
REQ-014 SHALL have port rd  input  DATA_W  memory read data, combinationally valid in the cycle MemRead is high.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, ACC, RSP.
REQ-016 SHALL, in IDLE, assert ready to at most one port, chosen by arbitration; ready SHALL be low in ACC and RSP.
REQ-017 SHALL arbitrate round-robin: if exactly one port is valid it wins; if both are valid, the port not granted most recently wins.
REQ-018 SHALL, on acceptance (valid && ready at the edge), latch owner, we, addr and wdata, update last-grant to the owner, and go IDLE -> ACC.
REQ-019 SHALL, in ACC, drive a = latched addr and wd = latched wdata, and assert exactly one of MemRead (load) or MemWrite (store) for exactly that cycle; then go ACC -> RSP.
REQ-020 SHALL, at the end of ACC on a load, capture rd into the rsp_rdata register; on a store, leave rsp_rdata unchanged.
REQ-021 SHALL, in RSP, pulse the owner's rsp_valid high for exactly one cycle with the other rsp_valid low; then go RSP -> IDLE.
REQ-022 SHALL give fixed latency: acceptance edge at cycle N, memory strobe in cycle N+1, rsp_valid in cycle N+2; next acceptance no earlier than cycle N+3.
REQ-023 SHALL hold MemRead, MemWrite, a and wd at 0 in IDLE and RSP.
REQ-024 SHALL never assert MemRead and MemWrite simultaneously, nor both readys, nor both rsp_valids.
REQ-025 SHALL ignore valid changes outside IDLE; a requester holds valid and payload stable until its ready is sampled.
REQ-026 SHALL treat addresses as opaque; no range checking, and address 2^DM_ADDRESS-1 is passed unmodified.

Reset
REQ-027 SHALL, on reset assertion, immediately and asynchronously force state IDLE, last-grant = port 1 (so port 0 wins the first tie), all readys, rsp_valids, MemRead and MemWrite to 0, a, wd and rsp_rdata to 0.
REQ-028 SHALL abort any in-flight access on reset with no rsp_valid generated; the first acceptance after reset is possible in the first cycle with reset low.

Verification
REQ-029 SHALL pass: port 0 store addr 0x005 data 0xDEAD_BEEF_0000_0001, then load addr 0x005 -> MemWrite in cycle N+1 with a=0x005; r0_rsp_valid at N+2; load returns rsp_rdata 0xDEAD_BEEF_0000_0001.
REQ-030 SHALL pass: both ports valid continuously from reset -> grants alternate 0,1,0,1 with acceptances every 3 cycles.
REQ-031 SHALL pass: only port 1 valid for 3 requests -> all three granted to port 1 with no idle gaps beyond the 3-cycle cadence.
REQ-032 SHALL pass: reset asserted during ACC of a port 0 load -> MemRead drops without waiting for a clock edge, no r0_rsp_valid, and both ports are re-arbitrated once reset is released.
REQ-033 SHALL pass: load addr 0x1FF after a store of 0x0123 to 0x1FF -> a=0x1FF, rsp_rdata 0x0123.
REQ-034 SHALL pass: port 1 store followed by a port 0 load -> rsp_rdata retains the previous load value during and after r1_rsp_valid.
